// File: rtl/patterns_pkg.sv
// Shared definitions for the pattern pipeline: work-mode codes, line timing
// state encoding and default timing constants.
package patterns_pkg;

    typedef enum logic [2:0] {
        REGULAR   = 3'b001,
        CONST     = 3'b010,
        WHITE1x1  = 3'b011,
        BLACK1x1  = 3'b100,
        WHITE2x2  = 3'b101,
        BLACK2x2  = 3'b110,
        RAMP_MODE = 3'b111
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SYNC   = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_BLANK  = 2'd3
    } tg_state_e;

    localparam int DEF_TEST_LEN = 1290;
    localparam int DEF_NORM_LEN = 4096;
    localparam int DEF_LINES    = 32;
    localparam int DEF_BLANK    = 16;
    localparam int DEF_PW       = 13;

endpackage

// File: rtl/tg_term_counter.sv
// Loadable up-counter with a terminal-count flag; used for the pixel index,
// the blanking gap and the line index of line_timing_gen.
module tg_term_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    input  logic [W-1:0] i_term,
    output logic [W-1:0] o_cnt,
    output logic         o_tc
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_cnt = r_cnt;
    assign o_tc  = (r_cnt == i_term);

endmodule

// File: rtl/line_timing_gen.sv
// Line/frame timing strobe generator for the pattern Control FSM.
// Optional macro CONT_FRAME_EN: back-to-back frames while run stays high.
module line_timing_gen
    import patterns_pkg::*;
#(
    parameter int TEST_LEN = DEF_TEST_LEN,
    parameter int NORM_LEN = DEF_NORM_LEN,
    parameter int LINES    = DEF_LINES,
    parameter int BLANK    = DEF_BLANK,
    parameter int PW       = DEF_PW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          run,
    input  logic          abort,
    input  logic [2:0]    Mode,
    output logic          f_sync,
    output logic          sync,
    output logic          endLine,
    output logic          endFrame,
    output logic [4:0]    line_idx,
    output logic [PW-1:0] pix_cnt,
    output logic          busy
);

    localparam int            BW         = (BLANK > 1) ? $clog2(BLANK) : 1;
    localparam logic [PW-1:0] TEST_LAST  = PW'(TEST_LEN - 1);
    localparam logic [PW-1:0] NORM_LAST  = PW'(NORM_LEN - 1);
    localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK - 1);
    localparam logic [4:0]    LINE_LAST  = 5'(LINES - 1);

    tg_state_e     r_state;
    tg_state_e     w_state_next;
    logic [2:0]    r_mode;
    logic          w_frame_start;
    logic [PW-1:0] w_len_last;

    logic          w_pix_load, w_pix_en, w_pix_tc;
    logic [PW-1:0] w_pix_cnt;
    logic          w_gap_load, w_gap_en, w_gap_tc;
    logic [BW-1:0] w_gap_cnt;
    logic          w_line_load, w_line_en, w_line_tc;
    logic [4:0]    w_line_idx;

    assign w_len_last = (r_mode == REGULAR) ? NORM_LAST : TEST_LAST;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_mode  <= 3'b000;
        end else begin
            r_state <= w_state_next;
            if (w_frame_start) begin
                r_mode <= Mode;
            end
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_frame_start = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (run) begin
                    w_state_next  = ST_SYNC;
                    w_frame_start = 1'b1;
                end
            end
            ST_SYNC:   w_state_next = ST_ACTIVE;
            ST_ACTIVE: begin
                if (w_pix_tc) begin
                    w_state_next = ST_BLANK;
                end
            end
            ST_BLANK: begin
                if (w_gap_tc) begin
                    if (!w_line_tc) begin
                        w_state_next = ST_SYNC;
                    end
`ifdef CONT_FRAME_EN
                    else if (run) begin
                        w_state_next  = ST_SYNC;
                        w_frame_start = 1'b1;
                    end
`endif
                    else begin
                        w_state_next = ST_IDLE;
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase

        // abort overrides everything, including a frame start in the same cycle
        if (abort) begin
            w_state_next  = ST_IDLE;
            w_frame_start = 1'b0;
        end

        w_pix_load  = (w_state_next == ST_IDLE) || (w_state_next == ST_SYNC);
        w_pix_en    = (r_state == ST_ACTIVE) && (w_state_next == ST_ACTIVE);
        w_gap_load  = (w_state_next != ST_BLANK);
        w_gap_en    = (r_state == ST_BLANK) && (w_state_next == ST_BLANK);
        w_line_load = (w_state_next == ST_IDLE) || w_frame_start;
        w_line_en   = (r_state == ST_BLANK) && (w_state_next == ST_SYNC) && !w_frame_start;
    end

    tg_term_counter #(.W(PW)) u_pix_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_pix_load),
        .i_load_val ('0),
        .i_en       (w_pix_en),
        .i_term     (w_len_last),
        .o_cnt      (w_pix_cnt),
        .o_tc       (w_pix_tc)
    );

    tg_term_counter #(.W(BW)) u_gap_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_gap_load),
        .i_load_val ('0),
        .i_en       (w_gap_en),
        .i_term     (BLANK_LAST),
        .o_cnt      (w_gap_cnt),
        .o_tc       (w_gap_tc)
    );

    tg_term_counter #(.W(5)) u_line_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_line_load),
        .i_load_val ('0),
        .i_en       (w_line_en),
        .i_term     (LINE_LAST),
        .o_cnt      (w_line_idx),
        .o_tc       (w_line_tc)
    );

    // Strobes are pure decodes of registered state/counters
    assign sync     = (r_state == ST_SYNC);
    assign f_sync   = sync && (w_line_idx == 5'd0);
    assign endLine  = (r_state == ST_ACTIVE) && w_pix_tc;
    assign endFrame = (r_state != ST_IDLE) && w_line_tc;
    assign busy     = (r_state != ST_IDLE);
    assign line_idx = w_line_idx;
    assign pix_cnt  = w_pix_cnt;

    logic w_unused;
    assign w_unused = ^w_gap_cnt;

endmodule

// File: tb/tb_line_timing_gen.sv
// Self-checking bench for line_timing_gen: scoreboard of per-cycle expected
// strobes, a table of fixed checkpoints, and hand-written corner sequences.
module tb_line_timing_gen;

    localparam int S_LEN   = 8;
    localparam int S_NORM  = 20;
    localparam int S_LINES = 3;
    localparam int S_BLANK = 2;
    localparam int PW      = 13;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          run = 1'b0, abort = 1'b0;
    logic [2:0]    mode = 3'b000;
    logic          f_sync, sync, end_line, end_frame, busy;
    logic [4:0]    line_idx;
    logic [PW-1:0] pix_cnt;

    logic          run2 = 1'b0, abort2 = 1'b0;
    logic [2:0]    mode2 = 3'b000;
    logic          f_sync2, sync2, end_line2, end_frame2, busy2;
    logic [4:0]    line_idx2;
    logic [PW-1:0] pix_cnt2;

    always #8 clk = ~clk;

    line_timing_gen #(
        .TEST_LEN(S_LEN), .NORM_LEN(S_NORM), .LINES(S_LINES), .BLANK(S_BLANK), .PW(PW)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .run(run), .abort(abort), .Mode(mode),
        .f_sync(f_sync), .sync(sync), .endLine(end_line), .endFrame(end_frame),
        .line_idx(line_idx), .pix_cnt(pix_cnt), .busy(busy)
    );

    line_timing_gen u_dut2 (
        .clk(clk), .rst_n(rst_n), .run(run2), .abort(abort2), .Mode(mode2),
        .f_sync(f_sync2), .sync(sync2), .endLine(end_line2), .endFrame(end_frame2),
        .line_idx(line_idx2), .pix_cnt(pix_cnt2), .busy(busy2)
    );

    typedef struct packed {
        logic          sync;
        logic          f_sync;
        logic          end_line;
        logic          end_frame;
        logic          busy;
        logic [4:0]    line;
        logic [PW-1:0] pix;
    } obs_t;

    typedef struct {
        int   cyc;
        logic sync, f_sync, end_line, end_frame, busy;
    } vec_t;

    int   total = 0;
    int   bad = 0;
    obs_t sb_q[$];
    obs_t hist[0:63];
    vec_t tbl[12];

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    function automatic obs_t sample1();
        obs_t o;
        o.sync = sync; o.f_sync = f_sync; o.end_line = end_line;
        o.end_frame = end_frame; o.busy = busy; o.line = line_idx; o.pix = pix_cnt;
        return o;
    endfunction

    // Reference timing: cycle t of a frame (t=1 is the first sync)
    function automatic obs_t exp_at(input int t, input int len);
        obs_t e = '0;
        int per = 1 + len + S_BLANK;
        int p, r;
        if (t < 1) return e;
        p = (t - 1) / per;
        r = (t - 1) % per;
        if (p >= S_LINES) return e;
        e.busy = 1'b1;
        e.line = p[4:0];
        e.end_frame = (p == S_LINES - 1);
        if (r == 0) begin
            e.sync = 1'b1;
            e.f_sync = (p == 0);
        end else if (r <= len) begin
            e.pix = PW'(r - 1);
            e.end_line = (r == len);
        end else begin
            e.pix = PW'(len - 1);
        end
        return e;
    endfunction

    // Compare observation with expectation; pixel index is not defined during sync
    task automatic chk_obs(input string nm, input obs_t a, input obs_t e);
        obs_t m = '1;
        if (e.sync) m.pix = '0;
        chk(nm, 64'(a & m), 64'(e & m));
    endtask

    task automatic run_frame(input string nm, input int len, input int tail,
                             input int sw_t, input logic [2:0] sw_mode);
        int   n = S_LINES * (1 + len + S_BLANK) + tail;
        int   ef_el = 0;
        obs_t a, e;
        for (int t = 1; t <= n; t++) sb_q.push_back(exp_at(t, len));
        hist[0] = sample1();
        run = 1'b1;
        for (int t = 1; t <= n; t++) begin
            @(negedge clk);
            a = sample1();
            e = sb_q.pop_front();
            if (t < 64) hist[t] = a;
            chk_obs($sformatf("%s t=%0d", nm, t), a, e);
            chk($sformatf("%s sync&endLine t=%0d", nm, t), 64'(a.sync & a.end_line), 64'(0));
            if (a.end_frame && a.end_line) ef_el++;
            if (t == 1) run = 1'b0;
            if (t == sw_t) mode = sw_mode;
        end
        chk({nm, " endFrame&endLine count"}, 64'(ef_el), 64'(1));
        $display("frame %s: %0d cycles checked", nm, n);
    endtask

    initial begin
        obs_t e;

        tbl[0]  = '{0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[2]  = '{2,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[3]  = '{9,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[4]  = '{10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[5]  = '{12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[6]  = '{20, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[7]  = '{22, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[8]  = '{23, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[9]  = '{31, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        tbl[10] = '{33, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[11] = '{34, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset outputs", 64'(sample1()), 64'(0));
        chk("reset busy2", 64'(busy2), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);
        $display("reset released");

        // Single frame, then checkpoints from the table
        mode = 3'b010;
        run_frame("frame", S_LEN, 3, 0, 3'b000);
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("tbl cyc%0d", tbl[i].cyc),
                64'({hist[tbl[i].cyc].sync, hist[tbl[i].cyc].f_sync, hist[tbl[i].cyc].end_line,
                     hist[tbl[i].cyc].end_frame, hist[tbl[i].cyc].busy}),
                64'({tbl[i].sync, tbl[i].f_sync, tbl[i].end_line, tbl[i].end_frame, tbl[i].busy}));
        end

        // Mode change on line 1 is ignored; next frame uses the new length
        mode = 3'b010;
        run_frame("modechg", S_LEN, 2, 15, 3'b001);
        run_frame("regular_small", S_NORM, 2, 0, 3'b000);
        mode = 3'b000;
        run_frame("invalid_mode", S_LEN, 2, 0, 3'b000);

        // abort at pix_cnt=4 on line 1, run held high
        mode = 3'b010;
        run = 1'b1;
        repeat (17) @(negedge clk);
        chk("abort pre pix", 64'(pix_cnt), 64'(4));
        chk("abort pre line", 64'(line_idx), 64'(1));
        abort = 1'b1;
        @(negedge clk);
        chk("abort idle", 64'(sample1()), 64'(0));
        abort = 1'b0;
        @(negedge clk);
        e = '0; e.sync = 1'b1; e.f_sync = 1'b1; e.busy = 1'b1;
        chk_obs("abort restart", sample1(), e);
        run = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        chk("abort from sync", 64'(busy), 64'(0));
        abort = 1'b0;
        @(negedge clk);
        $display("abort sequence done");

        // Asynchronous reset during ACTIVE
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid active pix", 64'(pix_cnt), 64'(3));
        rst_n = 1'b0;
        #1;
        chk("async reset", 64'(sample1()), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post reset idle", 64'(sample1()), 64'(0));
        $display("reset-in-line sequence done");

        // run held high across the frame end
        run = 1'b1;
        repeat (33) @(negedge clk);
        e = '0; e.end_frame = 1'b1; e.busy = 1'b1; e.line = 5'd2; e.pix = PW'(S_LEN - 1);
        chk_obs("cont last blank", sample1(), e);
        @(negedge clk);
`ifdef CONT_FRAME_EN
        e = '0; e.sync = 1'b1; e.f_sync = 1'b1; e.busy = 1'b1;
`else
        e = '0;
`endif
        chk_obs("cont t34", sample1(), e);
        @(negedge clk);
`ifdef CONT_FRAME_EN
        e = '0; e.busy = 1'b1;
`else
        e = '0; e.sync = 1'b1; e.f_sync = 1'b1; e.busy = 1'b1;
`endif
        chk_obs("cont t35", sample1(), e);
        run = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        chk("cont stop", 64'(busy), 64'(0));
        abort = 1'b0;
        $display("back-to-back sequence done");

        // REGULAR mode with default parameters
        mode2 = 3'b001;
        run2 = 1'b1;
        for (int t = 1; t <= 4114; t++) begin
            @(negedge clk);
            if (t == 1) begin
                run2 = 1'b0;
                chk("reg sync", 64'({sync2, f_sync2, line_idx2}), 64'({1'b1, 1'b1, 5'd0}));
            end
            if (t == 4096)
                chk("reg pix4094", 64'({end_line2, pix_cnt2}), 64'({1'b0, 13'd4094}));
            if (t == 4097)
                chk("reg endLine", 64'({end_line2, pix_cnt2}), 64'({1'b1, 13'd4095}));
            if (t == 4114)
                chk("reg line1 sync", 64'({sync2, f_sync2, line_idx2}), 64'({1'b1, 1'b0, 5'd1}));
        end
        abort2 = 1'b1;
        @(negedge clk);
        chk("reg abort", 64'(busy2), 64'(0));
        abort2 = 1'b0;
        $display("regular-mode line done");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/line_timing_gen.md
Name: line_timing_gen

Overview:
Upstream timing source for the pattern Control FSM. It generates the per-line and per-frame timing strobes that Control consumes: f_sync, sync, endLine and endFrame. Line length depends on the work mode: regular Gray count uses 4096 values, test modes use 1290 values. The block frames a fixed number of lines, separated by blanking gaps, on each run request.

Parameters:
TEST_LEN, 1290, active cycles per line in test modes (Mode != 3'b001)
NORM_LEN, 4096, active cycles per line in REGULAR mode (Mode == 3'b001)
LINES, 32, lines per frame (line counter is 5 bits)
BLANK, 16, idle cycles between end of one line and the next sync; must be >= 1
PW, 13, pix_cnt width; must hold NORM_LEN-1

Ports:
clk  in  1  16 ns master clock
rst_n  in  1  reset, asynchronous, active-low
run  in  1  level request to produce frames; sampled in IDLE and at frame end
abort  in  1  synchronous kill; forces IDLE on the next edge
Mode  in  3  work mode; latched at frame start
f_sync  out  1  high with sync on line 0 only
sync  out  1  one-cycle line-start pulse
endLine  out  1  high in the last active cycle of each line
endFrame  out  1  high for the whole of the last line (SYNC through BLANK)
line_idx  out  5  current line, 0..LINES-1
pix_cnt  out  PW  active-cycle index within the line
busy  out  1  high in any state other than IDLE

Behaviour:
- Clock and reset: clk rising edge; reset rst_n, asynchronous, active-low.
- Registered outputs: all outputs are registered and decoded from the state and counters; there are no combinational input-to-output paths.
- Reset values: state=IDLE; all outputs 0; latched mode=0.
- State IDLE:
  - If run=1 and abort=0 at edge k: latch Mode, clear line_idx, go to SYNC. sync and f_sync are therefore high in cycle k+1.
- State SYNC (1 cycle):
  - sync=1; f_sync=(line_idx==0); endFrame=(line_idx==LINES-1).
  - Next state: ACTIVE with pix_cnt=0.
- State ACTIVE (len cycles):
  - len = NORM_LEN if latched mode==3'b001, else TEST_LEN.
  - pix_cnt increments by 1 each cycle from 0.
  - endLine=1 only while pix_cnt==len-1.
  - Next state: BLANK.
- State BLANK (BLANK cycles):
  - Internal gap counter; pix_cnt holds at len-1.
  - endLine=0.
  - Not last line: line_idx+1, go to SYNC.
  - Last line: go to IDLE (see CONT_FRAME_EN).
- Line period: 1+len+BLANK cycles.
- Mode changes mid-frame: ignored until the next frame start.
- run deasserted mid-frame: the current frame completes; no new frame starts.
- abort: highest priority in every state. Next cycle is IDLE with all outputs 0. Any sync/endLine in the abort cycle is suppressed from the next cycle onward.
- Reset mid-line: immediate return to IDLE; no partial strobes.
- Invalid latched Mode (000): frame still runs with TEST_LEN. Control itself returns to IDLE.
- Invariants:
  - sync and endLine are never high in the same cycle.
  - endFrame&endLine is high exactly once per frame.

Optional Feature:
- Macro: CONT_FRAME_EN.
- Defined: at the end of BLANK on the last line, if run=1, go directly to SYNC with line_idx=0 (f_sync=1), relatching Mode. Frames run back-to-back with no IDLE cycle.
- Not defined: always return to IDLE for at least one cycle. The next frame's sync then comes ≥2 cycles after BLANK ends.

Decomposition:
- Shared package patterns_pkg:
  - mode codes REGULAR=3'b001, CONST=3'b010, WHITE1x1=3'b011, BLACK1x1=3'b100, WHITE2x2=3'b101, BLACK2x2=3'b110, RAMP_MODE=3'b111
  - state encoding IDLE/SYNC/ACTIVE/BLANK
  - default TEST_LEN/NORM_LEN/LINES
- One sub-module: tg_term_counter. It is a loadable up-counter with a terminal-count flag, instantiated for pix_cnt, the blank gap and line_idx.

Test Plan:
- Single frame:
  - Setup: TEST_LEN=8, LINES=3, BLANK=2, Mode=3'b010, run pulse at cycle 0.
  - sync at cycles 1, 12, 23; f_sync only at cycle 1.
  - endLine at cycles 9, 20, 31; endFrame high cycles 23–33.
  - busy low from cycle 34.
- REGULAR mode (defaults): Mode=3'b001 -> pix_cnt runs 0..4095; endLine at pix_cnt=4095; 4113-cycle line period.
- Mode change mid-frame: Mode 010 -> 001 during line 1 -> line lengths stay 8 until the next frame.
- abort:
  - abort asserted while pix_cnt=4 on line 1 -> next cycle state IDLE, all outputs 0.
  - With run still 1, a new frame starts and sync reappears one cycle later with f_sync=1.
- Reset during ACTIVE -> outputs 0 immediately (asynchronous), line_idx=0.
- run held high at frame end (small parameters):
  - With CONT_FRAME_EN: next sync comes the cycle after the last BLANK cycle, with f_sync=1.
  - Without it: one IDLE cycle appears, then sync.
